// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with one-hot registered grant and a single turnaround state.
// Define ARB_TIMEOUT_EN to force release of grants held for MAX_HOLD cycles.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] req,
    output logic       any_req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_gnt;
    logic [1:0] r_idx;
    logic       r_valid;
    logic       r_timeout;
    logic [1:0] w_winner;
    logic [1:0] w_cand;
    logic       w_found;
    logic       w_force;

    assign any_req   = |req;
    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;
    assign timeout   = r_timeout;

    // Scan from ptr upward, wrapping, and take the first active request
    always_comb begin
        w_winner = r_ptr;
        w_cand   = r_ptr;
        w_found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold_cnt;

    assign w_force = (r_hold_cnt == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (!rstn)                   r_hold_cnt <= 8'd0;
        else if (r_state == BUSY)    r_hold_cnt <= r_hold_cnt + 8'd1;
        else                         r_hold_cnt <= 8'd0;
    end
`else
    // Grants never expire in this build; the expression is constant false over the legal range
    assign w_force = (MAX_HOLD == 0);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_gnt     <= 4'd0;
            r_idx     <= 2'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (any_req) begin
                        r_state <= BUSY;
                        r_gnt   <= 4'b0001 << w_winner;
                        r_idx   <= w_winner;
                        r_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!req[r_idx] || w_force) begin
                        r_state   <= TURN;
                        r_gnt     <= 4'd0;
                        r_valid   <= 1'b0;
                        r_ptr     <= r_idx + 2'd1;
                        r_timeout <= req[r_idx] && w_force;
                    end
                end
                TURN:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed plus random bench for rr_arbiter4 against a holder/turnaround reference model.
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] req;
    logic       any_req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: who holds the resource, how long, and dead cycles left
    int m_holder = -1;
    int m_held   = 0;
    int m_dead   = 0;
    int m_ptr    = 0;
    int m_last   = 0;
    bit m_tmo    = 1'b0;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .any_req  (any_req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_edge(input logic [3:0] r, input logic rn);
        m_tmo = 1'b0;
        if (!rn) begin
            m_holder = -1; m_held = 0; m_dead = 0; m_ptr = 0; m_last = 0;
        end else if (m_holder >= 0) begin
            if (!r[m_holder] || (TMO && m_held == MAX_HOLD)) begin
                m_tmo    = r[m_holder];
                m_ptr    = (m_holder + 1) % 4;
                m_holder = -1;
                m_dead   = 1;
            end else begin
                m_held++;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (r != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_holder < 0 && r[(m_ptr + k) % 4]) m_holder = (m_ptr + k) % 4;
            end
            m_last = m_holder;
            m_held = 1;
        end
    endtask

    // Drive one cycle: inputs after the edge, check any_req, clock, then check registered outputs
    task automatic cyc(input logic [3:0] r, input logic rn);
        logic [3:0] eg;
        req  = r;
        rstn = rn;
        #1;
        chk("any_req", {7'd0, any_req}, {7'd0, |r});
        @(posedge clk);
        model_edge(r, rn);
        #1;
        eg = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'd0;
        chk("gnt",       {4'd0, gnt},       {4'd0, eg});
        chk("gnt_idx",   {6'd0, gnt_idx},   8'(m_last));
        chk("gnt_valid", {7'd0, gnt_valid}, {7'd0, m_holder >= 0});
        chk("timeout",   {7'd0, timeout},   {7'd0, m_tmo});
    endtask

    initial begin
        int order[$];
        int exp_order[5];
        int hi_cnt, to_cnt;
        bit prev_v;
        logic [3:0] r;

        exp_order = '{0, 1, 2, 3, 0};
        req  = 4'd0;
        rstn = 1'b0;
        @(posedge clk);
        #1;

        // T1 reset with all requesting
        repeat (3) cyc(4'b1111, 1'b0);

        // T2 single requester
        cyc(4'b0100, 1'b1);
        chk("t2_gnt", {4'd0, gnt}, 8'h04);
        chk("t2_idx", {6'd0, gnt_idx}, 8'd2);
        repeat (2) cyc(4'b0100, 1'b1);
        cyc(4'b0000, 1'b1);
        chk("t2_drop", {4'd0, gnt}, 8'h00);
        repeat (2) cyc(4'b0000, 1'b1);

        // T3 rotation from ptr=0, each holder releases after 3 grant cycles
        cyc(4'b0000, 1'b0);
        prev_v = 1'b0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            r = 4'b1111;
            if (m_holder >= 0 && m_held == 3) r[m_holder] = 1'b0;
            cyc(r, 1'b1);
            if (gnt_valid && !prev_v) order.push_back(int'(gnt_idx));
            prev_v = gnt_valid;
        end
        chk("t3_count", 8'(order.size()), 8'd5);
        for (int k = 0; k < 5 && k < order.size(); k++)
            chk("t3_order", 8'(order[k]), 8'(exp_order[k]));

        // T4 wrap: serve 3, then 0 wins; serve 0, then 3 wins
        cyc(4'b0000, 1'b0);
        cyc(4'b1000, 1'b1);
        cyc(4'b0000, 1'b1);
        repeat (2) cyc(4'b0000, 1'b1);
        cyc(4'b1001, 1'b1);
        chk("t4_wrap", {4'd0, gnt}, 8'h01);
        cyc(4'b1000, 1'b1);
        repeat (2) cyc(4'b1001, 1'b1);
        chk("t4_prio", {4'd0, gnt}, 8'h08);
        cyc(4'b0000, 1'b1);
        repeat (2) cyc(4'b0000, 1'b1);

        // T5 reset mid-grant
        cyc(4'b0010, 1'b1);
        chk("t5_gnt", {4'd0, gnt}, 8'h02);
        cyc(4'b0011, 1'b0);
        chk("t5_rst", {4'd0, gnt}, 8'h00);
        cyc(4'b0011, 1'b1);
        chk("t5_after", {4'd0, gnt}, 8'h01);

        // T6 long hold from a clean idle
        cyc(4'b0000, 1'b0);
        hi_cnt = 0;
        to_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(4'b0001, 1'b1);
            if (gnt == 4'b0001) hi_cnt++;
            if (timeout) to_cnt++;
        end
        chk("t6_hold", 8'(hi_cnt), TMO ? 8'd16 : 8'd20);
        chk("t6_tmo",  8'(to_cnt), TMO ? 8'd2  : 8'd0);

        // Random traffic with occasional reset; requests tend to persist
        r = 4'd0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cyc(r, ($urandom_range(0, 49) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
